// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
// ---------------------------------------------------------------------------
// Run controller for serial pattern detection. A host loads a PAT_W-bit
// pattern, a match target and a cycle timeout, then starts a run. The
// controller shifts qualified serial bits into a window. It reports each
// match with a one-cycle hit pulse and counts the matches. The run ends when
// the target count is reached, when the timeout expires, or on abort.
//
// Handshake: a config word transfers on any rising clock edge where
// cfg_valid and cfg_ready are both high. cfg_ready is high only when no run
// is active (IDLE or DONE). The host may hold cfg_valid high while
// cfg_ready is low; nothing is taken until both are high at an edge.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cfg_valid    in   config offer
//   cfg_ready    out  config can be accepted (IDLE or DONE)
//   cfg_pattern  in   pattern, MSB is the first bit received
//   cfg_target   in   matches that end a run, 0 = unlimited
//   cfg_timeout  in   run length limit in clock cycles, 0 = none
//   cfg_overlap  in   1 = overlapping matches allowed
//   start        in   begin a run (ignored while busy)
//   abort        in   terminate a run / leave DONE
//   bit_valid    in   bit_in qualifier
//   bit_in       in   serial data
//   busy         out  run in progress (FILL or SEARCH)
//   hit          out  one-cycle match pulse
//   match_count  out  matches in current/last run
//   done         out  run ended by target or timeout (level)
//   timed_out    out  run ended by timeout (valid with done)
//   dbg_state    out  current FSM state, for checkers
// ---------------------------------------------------------------------------
module seq_detect_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int TMO_W = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic [TMO_W-1:0] cfg_timeout,
  input  logic             cfg_overlap,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             timed_out,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int                FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_t state_q;
  state_t state_d;

  // Latched configuration
  logic [PAT_W-1:0]  pattern_q;
  logic [CNT_W-1:0]  target_q;
  logic [TMO_W-1:0]  timeout_q;
  logic              overlap_q;

  // Run datapath
  logic [PAT_W-1:0]  window_q;
  logic [FILL_W-1:0] fill_q;
  logic [TMO_W-1:0]  timer_q;

  // Per-edge decisions
  logic              run_active;
  logic              bit_take;
  logic [PAT_W-1:0]  win_next;
  logic [FILL_W-1:0] fill_next;
  logic              match;
  logic              target_hit;
  logic              tmo_hit;
  logic              cfg_fire;
  logic [CNT_W-1:0]  count_inc;

  // -------------------------------------------------------------------------
  // Decision logic shared by the FSM and the datapath
  // -------------------------------------------------------------------------
  always_comb begin
    run_active = (state_q == ST_FILL) || (state_q == ST_SEARCH);
    bit_take   = run_active && bit_valid;
    win_next   = {window_q[PAT_W-2:0], bit_in};
    fill_next  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    // fill_next saturates at PAT_W, so "== FULL" means "at least PAT_W bits".
    match      = bit_take && (fill_next == FILL_FULL) && (win_next == pattern_q);
    target_hit = match && (target_q != '0) && ((match_count + 1'b1) == target_q);
    // timer counts busy cycles already elapsed; this edge closes cycle timer+1.
    tmo_hit    = run_active && (timeout_q != '0) && (timer_q == timeout_q - 1'b1);
    cfg_fire   = cfg_valid && cfg_ready;
    count_inc  = (match_count == {CNT_W{1'b1}}) ? match_count : match_count + 1'b1;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // Busy priority: abort, then a target-completing match, then timeout,
  // then the non-overlap refill, then the FILL->SEARCH step.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FILL;
      end
      ST_FILL, ST_SEARCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (target_hit || tmo_hit) begin
          state_d = ST_DONE;
        end else if (match && !overlap_q) begin
          state_d = ST_FILL;
        end else if (bit_take && (fill_next == FILL_FULL)) begin
          state_d = ST_SEARCH;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == ST_FILL) || (state_q == ST_SEARCH);
    cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // -------------------------------------------------------------------------
  // Configuration registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= '0;
      target_q  <= CNT_W'(1);
      timeout_q <= '0;
      overlap_q <= 1'b1;
    end else if (cfg_fire) begin
      pattern_q <= cfg_pattern;
      target_q  <= cfg_target;
      timeout_q <= cfg_timeout;
      overlap_q <= cfg_overlap;
    end
  end

  // -------------------------------------------------------------------------
  // Run datapath: window, fill counter, timer, match counter and flags
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      window_q    <= '0;
      fill_q      <= '0;
      timer_q     <= '0;
      match_count <= '0;
      hit         <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      hit <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            window_q    <= '0;
            fill_q      <= '0;
            timer_q     <= '0;
            match_count <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (abort) begin
            done      <= 1'b0;
            timed_out <= 1'b0;
          end else if (start) begin
            window_q    <= '0;
            fill_q      <= '0;
            timer_q     <= '0;
            match_count <= '0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
          end
        end
        ST_FILL, ST_SEARCH: begin
          // An abort freezes everything, including a match on the same edge.
          if (!abort) begin
            timer_q <= timer_q + 1'b1;
            if (bit_take) begin
              window_q <= win_next;
              fill_q   <= (match && !overlap_q) ? '0 : fill_next;
            end
            if (match) begin
              hit         <= 1'b1;
              match_count <= count_inc;
            end
            if (target_hit) begin
              done      <= 1'b1;
              timed_out <= 1'b0;
            end else if (tmo_hit) begin
              done      <= 1'b1;
              timed_out <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
module tb_seq_detect_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int TMO_W = 12;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset_n;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_target;
  logic [TMO_W-1:0] cfg_timeout;
  logic             cfg_overlap;
  logic             start;
  logic             abort;
  logic             bit_valid;
  logic             bit_in;
  logic             busy;
  logic             hit;
  logic [CNT_W-1:0] match_count;
  logic             done;
  logic             timed_out;
  logic [1:0]       dbg_state;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_target  (cfg_target),
    .cfg_timeout (cfg_timeout),
    .cfg_overlap (cfg_overlap),
    .start       (start),
    .abort       (abort),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .busy        (busy),
    .hit         (hit),
    .match_count (match_count),
    .done        (done),
    .timed_out   (timed_out),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------------------------------------------------------------------
  // Reference model: a run is a history of accepted bits plus an elapsed
  // cycle count; a match is "the last PAT_W accepted bits spell the pattern".
  // ---------------------------------------------------------------------------
  int n_checks;
  int n_pass;

  logic [CNT_W-1:0] exp_q[$];   // expected match_count at each predicted hit

  bit hist[$];
  int m_pat, m_target, m_timeout;
  bit m_overlap;
  bit m_running, m_done, m_tmo;
  int m_count, m_elapsed;
  bit exp_hit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_pat = 0; m_target = 1; m_timeout = 0; m_overlap = 1'b1;
    m_running = 1'b0; m_done = 1'b0; m_tmo = 1'b0;
    m_count = 0; m_elapsed = 0; exp_hit = 1'b0;
    hist.delete();
    exp_q.delete();
  endtask

  function automatic int hist_value();
    int v;
    v = 0;
    foreach (hist[i]) v = (v << 1) | int'(hist[i]);
    return v;
  endfunction

  // Predicts the outputs after the coming rising edge from the current inputs.
  task automatic model_step();
    bit matched;
    exp_hit = 1'b0;
    if (cfg_valid && !m_running) begin
      m_pat     = int'(cfg_pattern);
      m_target  = int'(cfg_target);
      m_timeout = int'(cfg_timeout);
      m_overlap = cfg_overlap;
    end
    if (m_running) begin
      if (abort) begin
        m_running = 1'b0;
      end else begin
        m_elapsed++;
        matched = 1'b0;
        if (bit_valid) begin
          hist.push_back(bit_in);
          if (hist.size() > PAT_W) void'(hist.pop_front());
          if (hist.size() == PAT_W && hist_value() == m_pat) matched = 1'b1;
        end
        if (matched) begin
          exp_hit = 1'b1;
          if (m_count < CNT_MAX) m_count++;
          exp_q.push_back(CNT_W'(m_count));
          if (!m_overlap) hist.delete();
        end
        if (matched && m_target != 0 && m_count == m_target) begin
          m_running = 1'b0; m_done = 1'b1; m_tmo = 1'b0;
        end else if (m_timeout != 0 && m_elapsed == m_timeout) begin
          m_running = 1'b0; m_done = 1'b1; m_tmo = 1'b1;
        end
      end
    end else if (m_done && abort) begin
      m_done = 1'b0; m_tmo = 1'b0;
    end else if (start) begin
      m_running = 1'b1; m_done = 1'b0; m_tmo = 1'b0;
      m_count = 0; m_elapsed = 0;
      hist.delete();
    end
  endtask

  task automatic check_outputs();
    check("busy",        busy,        m_running);
    check("cfg_ready",   cfg_ready,   !m_running);
    check("done",        done,        m_done);
    check("timed_out",   timed_out,   m_tmo);
    check("match_count", match_count, m_count);
    check("hit",         hit,         exp_hit);
    if (hit === 1'b1) begin
      if (exp_q.size() == 0) check("hit_unexpected", hit, 0);
      else check("hit_count", match_count, exp_q.pop_front());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change at the falling edge)
  // ---------------------------------------------------------------------------
  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic abort_cycle();
    idle_inputs();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
  endtask

  task automatic cfg_and_start(input int pat, input int tgt, input int tmo, input bit ovl);
    idle_inputs();
    cfg_valid   = 1'b1;
    cfg_pattern = PAT_W'(pat);
    cfg_target  = CNT_W'(tgt);
    cfg_timeout = TMO_W'(tmo);
    cfg_overlap = ovl;
    start       = 1'b1;
    cycle();
    idle_inputs();
  endtask

  // Sends the low n bits of 'bits', MSB first; gap inserts an idle cycle.
  task automatic send_bits(input int bits, input int n, input bit gap);
    for (int i = n - 1; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = bits[i];
      cycle();
      bit_valid = 1'b0;
      if (gap) cycle();
    end
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_busy",      busy,        0);
    check("rst_hit",       hit,         0);
    check("rst_done",      done,        0);
    check("rst_timed_out", timed_out,   0);
    check("rst_count",     match_count, 0);
    check("rst_cfg_ready", cfg_ready,   1);
    model_reset();
    idle_inputs();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int first_done;
    n_checks = 0;
    n_pass   = 0;
    reset_n  = 1'b0;
    cfg_pattern = '0; cfg_target = '0; cfg_timeout = '0; cfg_overlap = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    check_outputs();

    // Overlap: 1011 in 1011011 -> two hits
    cfg_and_start(4'b1011, 0, 0, 1'b1);
    send_bits(7'b1011011, 7, 1'b0);
    check("ovl_count", match_count, 2);
    check("ovl_done",  done, 0);

    // Non-overlap: single hit
    abort_cycle();
    cfg_and_start(4'b1011, 0, 0, 1'b0);
    send_bits(7'b1011011, 7, 1'b0);
    check("novl_count", match_count, 1);

    // Target 2 with gaps; further bits ignored
    abort_cycle();
    cfg_and_start(4'b1011, 2, 0, 1'b1);
    send_bits(7'b1011011, 7, 1'b1);
    check("tgt_done",  done, 1);
    check("tgt_tmo",   timed_out, 0);
    check("tgt_busy",  busy, 0);
    send_bits(4'b1011, 4, 1'b0);
    check("tgt_count", match_count, 2);

    // Timeout 10 on zeros
    abort_cycle();
    cfg_and_start(4'b1111, 0, 10, 1'b1);
    first_done = 0;
    for (int i = 1; i <= 12; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b0;
      cycle();
      if (done === 1'b1 && first_done == 0) first_done = i;
    end
    check("tmo_latency", first_done, 10);
    check("tmo_flag",    timed_out, 1);
    check("tmo_count",   match_count, 0);

    // Final match coincident with timeout: match wins
    abort_cycle();
    cfg_and_start(4'b1011, 1, 4, 1'b1);
    send_bits(4'b1011, 4, 1'b0);
    check("coin_done", done, 1);
    check("coin_tmo",  timed_out, 0);

    // Abort mid-fill, then restart with 0110 via same-cycle config
    abort_cycle();
    cfg_and_start(4'b1011, 0, 0, 1'b1);
    send_bits(3'b101, 3, 1'b0);
    abort_cycle();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    cfg_and_start(4'b0110, 1, 0, 1'b1);
    send_bits(4'b0110, 4, 1'b0);
    check("abort_new_count", match_count, 1);
    check("abort_new_done",  done, 1);

    // Reset mid-SEARCH, then a run with the reset config (0000, target 1)
    abort_cycle();
    cfg_and_start(4'b1011, 0, 0, 1'b1);
    send_bits(5'b11100, 5, 1'b0);
    do_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    send_bits(4'b0000, 4, 1'b0);
    check("post_rst_count", match_count, 1);
    check("post_rst_done",  done, 1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end else begin
        cfg_valid   = ($urandom_range(0, 7) == 0);
        cfg_pattern = PAT_W'($urandom_range(0, (1 << PAT_W) - 1));
        cfg_target  = CNT_W'($urandom_range(0, 4));
        cfg_timeout = ($urandom_range(0, 2) == 0) ? '0 : TMO_W'($urandom_range(1, 40));
        cfg_overlap = 1'($urandom_range(0, 1));
        start       = ($urandom_range(0, 9) == 0);
        abort       = ($urandom_range(0, 39) == 0);
        bit_valid   = ($urandom_range(0, 3) != 0);
        bit_in      = 1'($urandom_range(0, 1));
        cycle();
      end
    end
    idle_inputs();

    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller for serial pattern detection. Accepts a programmable PAT_W-bit pattern, a match target and a cycle timeout over a valid/ready config handshake, then scans a qualified serial bit stream for the pattern. It reports each match, counts matches and ends the run on reaching the target, on timeout, or on abort. It sits between the host/control logic and the serial input path, in place of fixed-pattern Moore detectors.

## Interface
- PAT_W, 4: pattern length in bits (2..8)
- CNT_W, 8: match counter / target width
- TMO_W, 12: timeout counter width
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready at an edge
- cfg_pattern  in  PAT_W  pattern; MSB is the first bit received
- cfg_target  in  CNT_W  matches that end a run; 0 = unlimited
- cfg_timeout  in  TMO_W  run length limit in clock cycles; 0 = none
- cfg_overlap  in  1  1 = overlapping matches allowed
- start  in  1  begin a run (ignored while busy)
- abort  in  1  terminate a run
- bit_valid  in  1  bit_in qualifier
- bit_in  in  1  serial data
- busy  out  1  run in progress (FILL or SEARCH)
- hit  out  1  one-cycle match pulse
- match_count  out  CNT_W  matches in current/last run
- done  out  1  level; run ended by target or timeout
- timed_out  out  1  level; valid with done

## Operation
- Reset (reset_n low, async) values:
  - State IDLE; cfg_ready=1; busy, hit, done, timed_out and match_count = 0.
  - Config registers: pattern=0, target=1, timeout=0, overlap=1.
  - Window, fill counter and timer = 0.
- States:
  - IDLE: waiting for start.
  - FILL: fewer than PAT_W bits collected since start or since the last non-overlapping match.
  - SEARCH: compares on every valid bit.
  - DONE: run ended by target or timeout; held until start or abort.
- cfg_ready=1 in IDLE and DONE only. cfg_valid & cfg_ready latches all four config fields.
- If config and start occur in the same cycle, the new config applies to that run.
- start in IDLE/DONE:
  - Clears match_count, done, timed_out, window, fill counter and timer.
  - Goes to FILL.
- On each edge with bit_valid=1 in FILL/SEARCH, the next window is {window[PAT_W-2:0], bit_in} and the fill counter increments, saturating at PAT_W.
- FILL->SEARCH on the edge where the PAT_W-th bit arrives. That bit is already compared.
- Match condition: fill count including this bit >= PAT_W, and the next window equals the pattern.
- On a match:
  - hit is registered high for the next cycle only.
  - match_count increments; it saturates at all-ones when target=0.
  - If cfg_overlap=0, the fill counter clears and the state returns to FILL.
- Target reached (match_count+1 == target, target != 0): go to DONE on the same edge, done=1, timed_out=0.
- Timer:
  - Increments every busy cycle.
  - If cfg_timeout != 0 and timer == cfg_timeout-1 with no target-completing match on that edge: go to DONE, done=1, timed_out=1.
  - A run therefore lasts at most cfg_timeout busy cycles.
  - If the final match and the timeout coincide, the match wins and timed_out=0.
- abort:
  - In FILL/SEARCH: go to IDLE with no done; match_count is held and a pending hit is suppressed.
  - In DONE: go to IDLE and clear done and timed_out.
  - In IDLE: no effect; a simultaneous start is honoured.
  - When busy, abort takes priority over a match.
- Gaps in bit_valid do not break the window. Bits with bit_valid=0 are ignored; bit_in is then don't-care.

## Timing
- Config latency: fields take effect on the accepting edge.
- start edge N: busy=1 from cycle N+1.
- Match latency: bit sampled at edge N -> hit and the updated match_count are visible in cycle N+1.
- The final match raises hit and done together in cycle N+1; busy drops in the same cycle.
- Timeout: start at edge S -> done=1, timed_out=1 and busy=0 visible at S+cfg_timeout+1.
- Reset assertion mid-run forces the reset values immediately. The first start is accepted on the first edge after reset_n rises.

## Test plan
- Overlap: pattern 1011, overlap=1, target=0; stream 1,0,1,1,0,1,1 on consecutive cycles -> hit after bits 4 and 7, match_count=2, done=0.
- Non-overlap: same stream with overlap=0 -> single hit after bit 4, match_count=1.
- Target: pattern 1011, target=2, overlap=1; stream 1,0,1,1,0,1,1 with bit_valid low every other cycle -> second hit and done=1 in the same cycle, timed_out=0, busy=0, further bits ignored.
- Timeout: timeout=10, stream of zeros -> done=1, timed_out=1 exactly 11 cycles after the start edge, match_count=0. Also cover the coincident final-match/timeout case -> timed_out=0.
- Abort: abort after bits 1,0,1 -> IDLE, no hit, no done. Then a new start with pattern 0110 via cfg in the same cycle -> detects 0110.
- Reset mid-SEARCH: reset_n low -> all outputs 0 and cfg_ready=1 asynchronously; start after release runs normally with the reset config (pattern 0000, target 1).
